// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the control-store microsequencer.
package ctrl_seq_pkg;

    localparam int CS_ADDR_W    = 4;
    localparam int CS_OPCODE_W  = 4;
    localparam int CS_CW_W      = 10;
    localparam int CS_FETCH_LEN = 2;
    localparam int HLT_BIT      = CS_CW_W - 1;
    localparam int CNT_W        = 2;

    typedef logic [CS_ADDR_W-1:0]   uaddr_t;
    typedef logic [CS_OPCODE_W-1:0] opcode_t;
    typedef logic [CNT_W-1:0]       cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

    localparam opcode_t OP_NOP = 4'd0;
    localparam opcode_t OP_LDA = 4'd1;
    localparam opcode_t OP_ADD = 4'd2;
    localparam opcode_t OP_SUB = 4'd3;
    localparam opcode_t OP_OUT = 4'd4;
    localparam opcode_t OP_HLT = 4'd5;

    localparam uaddr_t UA_FETCH0 = 4'd0;
    localparam uaddr_t UA_FETCH1 = 4'd1;
    localparam uaddr_t UA_LDA    = 4'd2;
    localparam uaddr_t UA_ADD    = 4'd4;
    localparam uaddr_t UA_SUB    = 4'd6;
    localparam uaddr_t UA_OUT    = 4'd8;
    localparam uaddr_t UA_HLT    = 4'd9;
    localparam uaddr_t UA_NOP    = 4'd10;

    typedef struct packed {
        uaddr_t start;
        cnt_t   len;
        logic   is_hlt;
        logic   is_illegal;
    } dispatch_t;

endpackage

// File: rtl/control_sequencer_uop_dispatch_rom.sv
// Opcode to execute-routine lookup: start address, micro-op count, HLT/illegal flags.
// Purely combinational; no flow control.
module uop_dispatch_rom
    import ctrl_seq_pkg::*;
(
    input  opcode_t   opcode,
    output dispatch_t dispatch
);

    always_comb begin
        dispatch = '{start: UA_HLT, len: cnt_t'(1), is_hlt: 1'b0, is_illegal: 1'b1};
        case (opcode)
            OP_NOP:  dispatch = '{start: UA_NOP, len: cnt_t'(1), is_hlt: 1'b0, is_illegal: 1'b0};
            OP_LDA:  dispatch = '{start: UA_LDA, len: cnt_t'(2), is_hlt: 1'b0, is_illegal: 1'b0};
            OP_ADD:  dispatch = '{start: UA_ADD, len: cnt_t'(2), is_hlt: 1'b0, is_illegal: 1'b0};
            OP_SUB:  dispatch = '{start: UA_SUB, len: cnt_t'(2), is_hlt: 1'b0, is_illegal: 1'b0};
            OP_OUT:  dispatch = '{start: UA_OUT, len: cnt_t'(1), is_hlt: 1'b0, is_illegal: 1'b0};
            OP_HLT:  dispatch = '{start: UA_HLT, len: cnt_t'(1), is_hlt: 1'b1, is_illegal: 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microsequencer: fetch/decode/execute micro-address generation with HLT and illegal-opcode trap.
// One micro-address per cycle, zero-gap between instructions; mem_ready=0 freezes all state.
// SINGLE_STEP_EN: instructions start only on a step pulse in IDLE.
module control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int ADDR_W    = CS_ADDR_W,
    parameter int OPCODE_W  = CS_OPCODE_W,
    parameter int CW_W      = CS_CW_W,
    parameter int FETCH_LEN = CS_FETCH_LEN
) (
    input  logic                clk,
    input  logic                reset_control_word,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [CW_W-1:0]     control_word,
    input  logic                step,
    output logic [ADDR_W-1:0]   control_addr,
    output logic                halted,
    output logic                illegal_op,
    output logic                instr_done,
    output logic                busy
);

    localparam cnt_t FETCH_LAST = CNT_W'(FETCH_LEN - 1);

    seq_state_t state;
    cnt_t       uop_cnt;
    dispatch_t  dec;
    logic       start_ok;
    logic       cont_ok;

    uop_dispatch_rom u_rom (
        .opcode   (opcode),
        .dispatch (dec)
    );

`ifdef SINGLE_STEP_EN
    assign start_ok = run && step;
    assign cont_ok  = 1'b0;
`else
    logic unused_step;
    assign unused_step = step;
    assign start_ok    = run;
    assign cont_ok     = run;
`endif

    assign busy = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);

    // uop_cnt counts remaining micro-ops after the one currently issued.
    always_ff @(posedge clk or posedge reset_control_word) begin
        if (reset_control_word) begin
            state        <= ST_IDLE;
            control_addr <= UA_NOP;
            halted       <= 1'b0;
            illegal_op   <= 1'b0;
            instr_done   <= 1'b0;
            uop_cnt      <= '0;
        end else if (control_word[HLT_BIT]) begin
            state        <= ST_HALT;
            control_addr <= UA_HLT;
            halted       <= 1'b1;
            instr_done   <= 1'b0;
        end else if (mem_ready) begin
            instr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state        <= ST_FETCH;
                        control_addr <= UA_FETCH0;
                        uop_cnt      <= FETCH_LAST;
                    end
                end
                ST_FETCH: begin
                    if (uop_cnt == '0) begin
                        state        <= ST_DECODE;
                        control_addr <= UA_NOP;
                    end else begin
                        control_addr <= control_addr + ADDR_W'(1);
                        uop_cnt      <= uop_cnt - CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (dec.is_illegal || dec.is_hlt) begin
                        state        <= ST_HALT;
                        control_addr <= UA_HLT;
                        halted       <= 1'b1;
                        illegal_op   <= illegal_op | dec.is_illegal;
                    end else begin
                        state        <= ST_EXEC;
                        control_addr <= dec.start;
                        uop_cnt      <= dec.len - CNT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (uop_cnt == '0) begin
                        instr_done <= 1'b1;
                        if (cont_ok) begin
                            state        <= ST_FETCH;
                            control_addr <= UA_FETCH0;
                            uop_cnt      <= FETCH_LAST;
                        end else begin
                            state        <= ST_IDLE;
                            control_addr <= UA_NOP;
                        end
                    end else begin
                        control_addr <= control_addr + ADDR_W'(1);
                        uop_cnt      <= uop_cnt - CNT_W'(1);
                    end
                end
                ST_HALT: ;
                default: begin
                    state        <= ST_HALT;
                    control_addr <= UA_HLT;
                    halted       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus randomized run against a queue-based model.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset_control_word;
    logic       run;
    logic       mem_ready;
    logic [3:0] opcode;
    logic [9:0] control_word;
    logic       step;
    logic [3:0] control_addr;
    logic       halted;
    logic       illegal_op;
    logic       instr_done;
    logic       busy;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk                (clk),
        .reset_control_word (reset_control_word),
        .run                (run),
        .mem_ready          (mem_ready),
        .opcode             (opcode),
        .control_word       (control_word),
        .step               (step),
        .control_addr       (control_addr),
        .halted             (halted),
        .illegal_op         (illegal_op),
        .instr_done         (instr_done),
        .busy               (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an instruction is a queue of micro-addresses still to issue; DEC marks the decode slot.
    localparam int DEC = 100;
    int start_tab[5] = '{10, 2, 4, 6, 8};
    int len_tab[5]   = '{1, 2, 2, 2, 1};

    int m_mode;   // 0 idle, 1 running, 2 halted
    int m_addr;
    bit m_halted, m_illegal, m_done, m_at_dec;
    int m_q[$];

    function automatic bit go_ok();
`ifdef SINGLE_STEP_EN
        return run && step;
`else
        return run;
`endif
    endfunction

    function automatic bit cont_ok();
`ifdef SINGLE_STEP_EN
        return 1'b0;
`else
        return run;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_addr = 10; m_halted = 0; m_illegal = 0; m_done = 0; m_at_dec = 0;
        m_q.delete();
    endtask

    task automatic start_instr();
        m_mode = 1; m_addr = 0; m_at_dec = 0;
        m_q.delete();
        m_q.push_back(1);
        m_q.push_back(DEC);
    endtask

    task automatic model_step();
        int op;
        if (control_word[9]) begin
            m_mode = 2; m_addr = 9; m_halted = 1; m_done = 0; m_at_dec = 0;
            m_q.delete();
            return;
        end
        if (!mem_ready) return;
        m_done = 0;
        if (m_mode == 0) begin
            if (go_ok()) start_instr();
        end else if (m_mode == 1) begin
            if (m_at_dec) begin
                m_at_dec = 0;
                op = int'(opcode);
                if (op >= 5) begin
                    m_mode = 2; m_addr = 9; m_halted = 1;
                    if (op > 5) m_illegal = 1;
                end else begin
                    m_addr = start_tab[op];
                    for (int i = 1; i < len_tab[op]; i++) m_q.push_back(start_tab[op] + i);
                end
            end else if (m_q.size() != 0) begin
                int nxt;
                nxt = m_q.pop_front();
                if (nxt == DEC) begin
                    m_addr = 10; m_at_dec = 1;
                end else begin
                    m_addr = nxt;
                end
            end else begin
                m_done = 1;
                if (cont_ok()) start_instr();
                else begin
                    m_mode = 0; m_addr = 10;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("addr",    32'(control_addr), m_addr);
        chk("halted",  32'(halted),       32'(m_halted));
        chk("illegal", 32'(illegal_op),   32'(m_illegal));
        chk("done",    32'(instr_done),   32'(m_done));
        chk("busy",    32'(busy),         32'(m_mode == 1));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset_control_word) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Called at a falling edge; reset takes effect immediately, released a cycle later.
    task automatic do_reset();
        reset_control_word = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        reset_control_word = 1'b0;
    endtask

    int halt_len;
    int dones;
    int lda_seq[7]  = '{10, 0, 1, 10, 2, 3, 0};
    int lda_done[7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        reset_control_word = 1'b1;
        run = 1'b0; mem_ready = 1'b1; opcode = 4'd0; control_word = '0; step = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_addr", 32'(control_addr), 10);
        chk("rst_halted", 32'(halted), 0);

`ifdef SINGLE_STEP_EN
        run = 1'b1; opcode = 4'd0;
        repeat (3) cycle();
        chk("ss_wait_addr", 32'(control_addr), 10);
        dones = 0;
        repeat (2) begin
            step = 1'b1;
            cycle();
            step = 1'b0;
            repeat (8) begin
                cycle();
                dones += int'(instr_done);
            end
        end
        chk("ss_dones", dones, 2);
        chk("ss_idle_busy", 32'(busy), 0);
`else
        // LDA back-to-back
        opcode = 4'd1; run = 1'b1;
        chk("lda_addr0", 32'(control_addr), lda_seq[0]);
        for (int i = 1; i < 7; i++) begin
            cycle();
            chk("lda_addr", 32'(control_addr), lda_seq[i]);
            chk("lda_done", 32'(instr_done), lda_done[i]);
        end
        // done pulse stretches across a stall
        mem_ready = 1'b0;
        cycle();
        chk("done_stretch", 32'(instr_done), 1);
        mem_ready = 1'b1;

        // HLT opcode
        do_reset();
        opcode = 4'd5; run = 1'b1;
        repeat (4) cycle();
        chk("hlt_addr", 32'(control_addr), 9);
        chk("hlt_halted", 32'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom);
            cycle();
            chk("hlt_hold", 32'(control_addr), 9);
        end
        do_reset();
        chk("hlt_rst_addr", 32'(control_addr), 10);
        chk("hlt_rst_halted", 32'(halted), 0);

        // illegal opcode
        opcode = 4'd12; run = 1'b1;
        repeat (4) cycle();
        chk("ill_flag", 32'(illegal_op), 1);
        chk("ill_halted", 32'(halted), 1);
        chk("ill_addr", 32'(control_addr), 9);
        opcode = 4'd0;
        repeat (5) cycle();
        chk("ill_sticky", 32'(illegal_op), 1);
        do_reset();
        chk("ill_rst", 32'(illegal_op), 0);

        // stall at addr 2
        opcode = 4'd1; run = 1'b1;
        repeat (4) cycle();
        chk("stall_pre", 32'(control_addr), 2);
        mem_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("stall_hold", 32'(control_addr), 2);
        end
        mem_ready = 1'b1;
        cycle();
        chk("stall_next", 32'(control_addr), 3);
        cycle();
        chk("stall_fetch", 32'(control_addr), 0);

        // run dropped during ADD
        do_reset();
        opcode = 4'd2; run = 1'b1;
        repeat (4) cycle();
        chk("add_addr", 32'(control_addr), 4);
        run = 1'b0;
        cycle();
        chk("add_last", 32'(control_addr), 5);
        cycle();
        chk("add_idle", 32'(control_addr), 10);
        chk("add_done", 32'(instr_done), 1);
        chk("add_busy", 32'(busy), 0);
        cycle();
        chk("add_stay", 32'(control_addr), 10);
        run = 1'b1;
        cycle();
        chk("add_restart", 32'(control_addr), 0);

        // HLT bit injected during fetch
        do_reset();
        opcode = 4'd0; run = 1'b1;
        cycle();
        control_word = 10'b10_0000_0000;
        cycle();
        chk("inj_halted", 32'(halted), 1);
        chk("inj_addr", 32'(control_addr), 9);
        control_word = '0;
`endif

        // randomized phase
        do_reset();
        halt_len = 0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 9) == 0) run = ~run;
            mem_ready = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 9) == 0) opcode = 4'($urandom_range(5, 15));
            else opcode = 4'($urandom_range(0, 4));
            control_word = {($urandom_range(0, 149) == 0), 9'($urandom)};
            step = ($urandom_range(0, 7) == 0);
            halt_len = (m_mode == 2) ? halt_len + 1 : 0;
            if (halt_len > 6 || $urandom_range(0, 299) == 0) begin
                control_word = '0;
                do_reset();
                halt_len = 0;
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
